// File: rtl/ppg_pkg.sv
// ppg_pkg: shared definitions for the PPG operation-phase sequencer.
// Holds the sequencer state encoding, the channel tags carried with each
// averaged sample, the AFE code widths, and the phase-order helper.
// Optional feature macro: PPG_AMBIENT_PHASE_EN (inserts the AMB phase after IR).
package ppg_pkg;

  localparam int DC_W  = 7;
  localparam int PGA_W = 4;

  localparam logic [DC_W-1:0] DC_COMP_RESET = 7'd64;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RED  = 2'd1,
    ST_IR   = 2'd2,
    ST_AMB  = 2'd3
  } state_t;

  localparam logic [1:0] CH_RED = 2'd0;
  localparam logic [1:0] CH_IR  = 2'd1;
  localparam logic [1:0] CH_AMB = 2'd2;

  // Phase that follows the given one; AMB is only reachable with the feature.
  function automatic state_t next_phase(input state_t s);
    case (s)
      ST_RED:  next_phase = ST_IR;
`ifdef PPG_AMBIENT_PHASE_EN
      ST_IR:   next_phase = ST_AMB;
`else
      ST_IR:   next_phase = ST_RED;
`endif
      default: next_phase = ST_RED;
    endcase
  endfunction

  // Channel tag attached to a sample produced in the given phase.
  function automatic logic [1:0] ch_of(input state_t s);
    case (s)
      ST_RED:  ch_of = CH_RED;
      ST_IR:   ch_of = CH_IR;
      default: ch_of = CH_AMB;
    endcase
  endfunction

endpackage

// File: rtl/ppg_sample_avg.sv
// ppg_sample_avg: settle window and 4-sample accumulator for one LED phase.
// Ports:
//   CLK, rst  - system clock, asynchronous active-high reset
//   start     - high during the first cycle (cnt=0) of a phase; restarts the window
//   ADC       - ADC sample, valid every cycle
//   done      - high for one cycle (cnt=SETTLE+4) once four samples are summed
//   avg       - truncated average (sum>>2), meaningful while done is high
// No optional-feature macro is used in this file.
module ppg_sample_avg #(
  parameter int SETTLE = 4,
  parameter int ADC_W  = 8
) (
  input  logic             CLK,
  input  logic             rst,
  input  logic             start,
  input  logic [ADC_W-1:0] ADC,
  output logic             done,
  output logic [ADC_W-1:0] avg
);

  localparam int POS_W = $clog2(SETTLE + 5) + 1;
  localparam logic [POS_W-1:0] ACC_FIRST = POS_W'(SETTLE);
  localparam logic [POS_W-1:0] ACC_LAST  = POS_W'(SETTLE + 3);
  localparam logic [POS_W-1:0] DONE_POS  = POS_W'(SETTLE + 4);

  logic [POS_W-1:0] pos_q, pos_d;
  logic             active_q, active_d;
  logic [ADC_W+1:0] sum_q, sum_d;

  // pos_q tracks the phase counter from the cycle after start, so the
  // sample taken while pos_q is in ACC_FIRST..ACC_LAST is the one for cnt=SETTLE..SETTLE+3.
  always_comb begin
    pos_d    = pos_q;
    active_d = active_q;
    sum_d    = sum_q;
    if (start) begin
      pos_d    = POS_W'(1);
      active_d = 1'b1;
      sum_d    = '0;
    end else if (active_q) begin
      if (pos_q >= ACC_FIRST && pos_q <= ACC_LAST) begin
        sum_d = sum_q + {2'b00, ADC};
      end
      if (pos_q == DONE_POS) begin
        active_d = 1'b0;
      end else begin
        pos_d = pos_q + POS_W'(1);
      end
    end
  end

  always_ff @(posedge CLK or posedge rst) begin
    if (rst) begin
      pos_q    <= '0;
      active_q <= 1'b0;
      sum_q    <= '0;
    end else begin
      pos_q    <= pos_d;
      active_q <= active_d;
      sum_q    <= sum_d;
    end
  end

  assign done = active_q && (pos_q == DONE_POS);
  assign avg  = sum_q[ADC_W+1:2];

endmodule

// File: rtl/ppg_phase_sequencer.sv
// ppg_phase_sequencer: time-multiplexes the RED and IR LEDs of the PPG front
// end, drives the per-channel DC compensation / PGA gain, averages four ADC
// samples per phase after a settle window, and hands each result downstream
// through a one-entry valid/ready output register with a sticky overrun flag.
// Ports:
//   CLK, rst                  - clock, asynchronous active-high reset
//   enable                    - run sequencing; low returns to IDLE
//   cfg_load, cfg_*           - request new RED/IR DC and PGA settings
//   ADC                       - ADC sample input
//   LED_RED, LED_IR           - LED enables (never high together)
//   DC_Comp, PGA_Gain         - AFE settings for the current phase
//   sample_data/ch/valid/ready- averaged-sample output handshake
//   overrun, overrun_clr      - sticky dropped-sample flag and its clear
//   busy                      - high when not in IDLE
// Optional feature macro: PPG_AMBIENT_PHASE_EN adds an LED-off AMB phase after IR.
module ppg_phase_sequencer
  import ppg_pkg::*;
#(
  parameter int PHASE_LEN = 10,
  parameter int SETTLE    = 4,
  parameter int ADC_W     = 8
) (
  input  logic             CLK,
  input  logic             rst,
  input  logic             enable,
  input  logic             cfg_load,
  input  logic [DC_W-1:0]  cfg_red_dc,
  input  logic [PGA_W-1:0] cfg_red_pga,
  input  logic [DC_W-1:0]  cfg_ir_dc,
  input  logic [PGA_W-1:0] cfg_ir_pga,
  input  logic [ADC_W-1:0] ADC,
  output logic             LED_RED,
  output logic             LED_IR,
  output logic [DC_W-1:0]  DC_Comp,
  output logic [PGA_W-1:0] PGA_Gain,
  output logic [ADC_W-1:0] sample_data,
  output logic [1:0]       sample_ch,
  output logic             sample_valid,
  input  logic             sample_ready,
  output logic             overrun,
  input  logic             overrun_clr,
  output logic             busy
);

  localparam int CNT_W = $clog2(PHASE_LEN);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(PHASE_LEN - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             led_red_q, led_red_d, led_ir_q, led_ir_d;
  logic [DC_W-1:0]  dc_q, dc_d, red_dc_q, red_dc_d, ir_dc_q, ir_dc_d;
  logic [PGA_W-1:0] pga_q, pga_d, red_pga_q, red_pga_d, ir_pga_q, ir_pga_d;
  logic             pend_cfg_q, pend_cfg_d;
  logic [ADC_W-1:0] data_q, data_d;
  logic [1:0]       ch_q, ch_d;
  logic             valid_q, valid_d, overrun_q, overrun_d;

  logic             avg_start, avg_done;
  logic [ADC_W-1:0] avg_val;
  logic             phase_entry, red_entry, cfg_apply;
  logic             xfer, new_sample;

  // Phase sequencing: enable low always wins and parks the FSM in IDLE.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (state_q == ST_IDLE) begin
      if (enable) begin
        state_d = ST_RED;
        cnt_d   = '0;
      end
    end else if (!enable) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
    end else if (cnt_q == LAST) begin
      state_d = next_phase(state_q);
      cnt_d   = '0;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // cnt_d is only zero in an active state on the edge that enters a phase.
  assign phase_entry = (state_d != ST_IDLE) && (cnt_d == '0);
  assign red_entry   = phase_entry && (state_d == ST_RED);
  assign cfg_apply   = (pend_cfg_q || cfg_load) && ((state_q == ST_IDLE) || red_entry);

  // Sample averaging restarts on the first cycle of every active phase.
  assign avg_start  = (state_q != ST_IDLE) && (cnt_q == '0);
  assign new_sample = avg_done && (state_q != ST_IDLE) && enable;
  assign xfer       = valid_q && sample_ready;

  // Shadow config, AFE outputs and the output register.
  always_comb begin
    red_dc_d   = red_dc_q;
    red_pga_d  = red_pga_q;
    ir_dc_d    = ir_dc_q;
    ir_pga_d   = ir_pga_q;
    pend_cfg_d = pend_cfg_q || cfg_load;
    dc_d       = dc_q;
    pga_d      = pga_q;
    data_d     = data_q;
    ch_d       = ch_q;
    valid_d    = valid_q;
    overrun_d  = overrun_q;

    if (cfg_apply) begin
      red_dc_d   = cfg_red_dc;
      red_pga_d  = cfg_red_pga;
      ir_dc_d    = cfg_ir_dc;
      ir_pga_d   = cfg_ir_pga;
      pend_cfg_d = 1'b0;
    end

    // Break-before-make: the last cycle of every phase has both LEDs dark.
    led_red_d = (state_d == ST_RED) && (cnt_d != LAST);
    led_ir_d  = (state_d == ST_IR)  && (cnt_d != LAST);

    // AMB reuses the IR settings so the ambient reading matches the IR path.
    if (phase_entry) begin
      if (state_d == ST_RED) begin
        dc_d  = red_dc_d;
        pga_d = red_pga_d;
      end else begin
        dc_d  = ir_dc_d;
        pga_d = ir_pga_d;
      end
    end

    if (xfer) begin
      valid_d = 1'b0;
    end
    if (overrun_clr) begin
      overrun_d = 1'b0;
    end
    // A new result only replaces the held one if it is leaving this cycle.
    if (new_sample) begin
      if (!valid_q || xfer) begin
        data_d  = avg_val;
        ch_d    = ch_of(state_q);
        valid_d = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end
  end

  always_ff @(posedge CLK or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      led_red_q  <= 1'b0;
      led_ir_q   <= 1'b0;
      dc_q       <= DC_COMP_RESET;
      pga_q      <= '0;
      red_dc_q   <= DC_COMP_RESET;
      red_pga_q  <= '0;
      ir_dc_q    <= DC_COMP_RESET;
      ir_pga_q   <= '0;
      pend_cfg_q <= 1'b0;
      data_q     <= '0;
      ch_q       <= CH_RED;
      valid_q    <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      led_red_q  <= led_red_d;
      led_ir_q   <= led_ir_d;
      dc_q       <= dc_d;
      pga_q      <= pga_d;
      red_dc_q   <= red_dc_d;
      red_pga_q  <= red_pga_d;
      ir_dc_q    <= ir_dc_d;
      ir_pga_q   <= ir_pga_d;
      pend_cfg_q <= pend_cfg_d;
      data_q     <= data_d;
      ch_q       <= ch_d;
      valid_q    <= valid_d;
      overrun_q  <= overrun_d;
    end
  end

  ppg_sample_avg #(
    .SETTLE (SETTLE),
    .ADC_W  (ADC_W)
  ) u_avg (
    .CLK   (CLK),
    .rst   (rst),
    .start (avg_start),
    .ADC   (ADC),
    .done  (avg_done),
    .avg   (avg_val)
  );

  assign LED_RED      = led_red_q;
  assign LED_IR       = led_ir_q;
  assign DC_Comp      = dc_q;
  assign PGA_Gain     = pga_q;
  assign sample_data  = data_q;
  assign sample_ch    = ch_q;
  assign sample_valid = valid_q;
  assign overrun      = overrun_q;
  assign busy         = (state_q != ST_IDLE);

endmodule

// File: tb/tb_ppg_phase_sequencer.sv
// tb_ppg_phase_sequencer: self-checking bench for ppg_phase_sequencer.
// Expected samples are queued when their phase starts; a negedge monitor pops
// and compares whenever the DUT hands a sample over (valid && ready).
// Honours PPG_AMBIENT_PHASE_EN to expect the extra AMB phase.
module tb_ppg_phase_sequencer;
  import ppg_pkg::*;

`ifdef PPG_AMBIENT_PHASE_EN
  localparam int NPH = 3;
`else
  localparam int NPH = 2;
`endif

  logic       CLK = 1'b0;
  logic       rst, enable, cfg_load, sample_ready, overrun_clr;
  logic [6:0] cfg_red_dc, cfg_ir_dc;
  logic [3:0] cfg_red_pga, cfg_ir_pga;
  logic [7:0] ADC;
  logic       LED_RED, LED_IR, sample_valid, overrun, busy;
  logic [6:0] DC_Comp;
  logic [3:0] PGA_Gain;
  logic [7:0] sample_data;
  logic [1:0] sample_ch;

  typedef struct packed {
    logic [1:0] ch;
    logic [7:0] data;
  } sample_t;

  sample_t exp_q[$];
  sample_t mon_e;
  int checks = 0;
  int passed = 0;

  ppg_phase_sequencer dut (
    .CLK(CLK), .rst(rst), .enable(enable), .cfg_load(cfg_load),
    .cfg_red_dc(cfg_red_dc), .cfg_red_pga(cfg_red_pga),
    .cfg_ir_dc(cfg_ir_dc), .cfg_ir_pga(cfg_ir_pga), .ADC(ADC),
    .LED_RED(LED_RED), .LED_IR(LED_IR), .DC_Comp(DC_Comp), .PGA_Gain(PGA_Gain),
    .sample_data(sample_data), .sample_ch(sample_ch), .sample_valid(sample_valid),
    .sample_ready(sample_ready), .overrun(overrun), .overrun_clr(overrun_clr),
    .busy(busy)
  );

  always #5 CLK = ~CLK;

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual == expected) passed++;
    else $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
  endtask

  // Drive enable/ADC for the current cycle, then step to 1 time unit past the next edge.
  task automatic applyStimulus(input logic en, input int adc);
    enable = en;
    ADC    = 8'(adc);
    @(posedge CLK);
    #1;
  endtask

  task automatic doReset();
    rst = 1'b1; enable = 1'b0; cfg_load = 1'b0; overrun_clr = 1'b0;
    sample_ready = 1'b1; ADC = 8'd100;
    repeat (2) @(posedge CLK);
    #1;
    rst = 1'b0;
  endtask

  task automatic loadCfg(input int rd, input int rp, input int id, input int ip);
    cfg_red_dc = 7'(rd); cfg_red_pga = 4'(rp);
    cfg_ir_dc  = 7'(id); cfg_ir_pga  = 4'(ip);
    cfg_load = 1'b1;
    @(posedge CLK);
    #1;
    cfg_load = 1'b0;
  endtask

  task automatic waitDrain(input string name);
    int n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      @(posedge CLK);
      #1;
      n++;
    end
    checkOutput(name, exp_q.size(), 0);
  endtask

  // Scoreboard monitor: compares every handed-over sample with the queue head.
  always @(negedge CLK) begin
    if (!rst && sample_valid && sample_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        $display("[TB] FAIL unexpected_sample: got ch=%0d data=%0d, expected none",
                 sample_ch, sample_data);
      end else begin
        mon_e = exp_q.pop_front();
        checkOutput("sample_ch", int'(sample_ch), int'(mon_e.ch));
        checkOutput("sample_data", int'(sample_data), int'(mon_e.data));
      end
    end
  end

  initial begin
    int valid_seen;
    rst = 1'b1; enable = 1'b0; cfg_load = 1'b0; overrun_clr = 1'b0; sample_ready = 1'b1;
    ADC = 8'd100; cfg_red_dc = 7'd0; cfg_red_pga = 4'd0; cfg_ir_dc = 7'd0; cfg_ir_pga = 4'd0;

    // Reset values.
    doReset();
    checkOutput("rst_led_red", int'(LED_RED), 0);
    checkOutput("rst_led_ir", int'(LED_IR), 0);
    checkOutput("rst_dc", int'(DC_Comp), 64);
    checkOutput("rst_pga", int'(PGA_Gain), 0);
    checkOutput("rst_data", int'(sample_data), 0);
    checkOutput("rst_ch", int'(sample_ch), 0);
    checkOutput("rst_valid", int'(sample_valid), 0);
    checkOutput("rst_overrun", int'(overrun), 0);
    checkOutput("rst_busy", int'(busy), 0);

    // Full cycle plus a second RED phase with a ramp on the ADC.
    loadCfg(50, 3, 70, 5);
    applyStimulus(1'b1, 100);
    checkOutput("busy_run", int'(busy), 1);
    for (int k = 0; k < 10 * NPH + 10; k++) begin
      int p, c, ph, adc;
      p = k / 10; c = k % 10; ph = p % NPH;
      checkOutput("led_red", int'(LED_RED), (ph == 0 && c != 9) ? 1 : 0);
      checkOutput("led_ir", int'(LED_IR), (ph == 1 && c != 9) ? 1 : 0);
      if (c == 0) begin
        checkOutput("entry_dc", int'(DC_Comp), (ph == 0) ? 50 : 70);
        checkOutput("entry_pga", int'(PGA_Gain), (ph == 0) ? 3 : 5);
        exp_q.push_back('{ch: 2'(ph), data: (p == NPH) ? 8'd11 : 8'd100});
      end
      if (c == 8) checkOutput("valid_before", int'(sample_valid), 0);
      if (c == 9) checkOutput("valid_rise", int'(sample_valid), 1);
      adc = (p == NPH && c >= 4 && c <= 7) ? 10 + (c - 4) : 100;
      applyStimulus(1'b1, adc);
    end
    waitDrain("drain_cycle");

    // Held sample, dropped follower, overrun set wins over a same-cycle clear.
    doReset();
    loadCfg(50, 3, 70, 5);
    sample_ready = 1'b0;
    applyStimulus(1'b1, 100);
    exp_q.push_back('{ch: 2'd0, data: 8'd100});
    for (int k = 0; k < 20; k++) begin
      if (k == 18) overrun_clr = 1'b1;
      if (k == 9) begin
        checkOutput("held_valid", int'(sample_valid), 1);
        checkOutput("no_overrun_yet", int'(overrun), 0);
      end
      if (k == 19) begin
        checkOutput("overrun_set", int'(overrun), 1);
        checkOutput("held_still_valid", int'(sample_valid), 1);
        checkOutput("held_ch", int'(sample_ch), 0);
        checkOutput("held_data", int'(sample_data), 100);
        sample_ready = 1'b1;
      end
      applyStimulus(1'b1, 100);
    end
    overrun_clr = 1'b0;
    checkOutput("overrun_cleared", int'(overrun), 0);
    checkOutput("valid_after_xfer", int'(sample_valid), 0);
    applyStimulus(1'b0, 100);
    waitDrain("drain_overrun");

    // Config change requested mid-IR only lands at the next RED entry.
    doReset();
    loadCfg(50, 3, 70, 5);
    applyStimulus(1'b1, 100);
    for (int k = 0; k <= 10 * NPH; k++) begin
      int p, c;
      p = k / 10; c = k % 10;
      if (c == 0 && p < NPH) exp_q.push_back('{ch: 2'(p), data: 8'd100});
      if (k == 14 || k == 19) checkOutput("dc_hold_ir", int'(DC_Comp), 70);
      if (NPH == 3 && k == 20) checkOutput("amb_dc", int'(DC_Comp), 70);
      if (k == 10 * NPH) begin
        checkOutput("dc_new_red", int'(DC_Comp), 40);
        checkOutput("pga_new_red", int'(PGA_Gain), 3);
      end
      cfg_load = (k == 13);
      if (k == 13) cfg_red_dc = 7'd40;
      applyStimulus(1'b1, 100);
    end
    cfg_load = 1'b0;
    applyStimulus(1'b0, 100);
    waitDrain("drain_cfg");

    // enable drop mid-RED discards the phase; async reset mid-IR.
    doReset();
    loadCfg(50, 3, 70, 5);
    applyStimulus(1'b1, 100);
    for (int k = 0; k < 6; k++) applyStimulus((k == 5) ? 1'b0 : 1'b1, 100);
    checkOutput("drop_busy", int'(busy), 0);
    checkOutput("drop_led_red", int'(LED_RED), 0);
    valid_seen = 0;
    for (int k = 0; k < 10; k++) begin
      if (sample_valid) valid_seen = 1;
      applyStimulus(1'b0, 100);
    end
    checkOutput("drop_no_sample", valid_seen, 0);
    applyStimulus(1'b1, 100);
    exp_q.push_back('{ch: 2'd0, data: 8'd100});
    for (int k = 0; k < 15; k++) applyStimulus(1'b1, 100);
    checkOutput("ir_dc_before_rst", int'(DC_Comp), 70);
    checkOutput("ir_led_before_rst", int'(LED_IR), 1);
    rst = 1'b1;
    #2;
    checkOutput("async_rst_dc", int'(DC_Comp), 64);
    checkOutput("async_rst_led_ir", int'(LED_IR), 0);
    checkOutput("async_rst_busy", int'(busy), 0);
    @(posedge CLK);
    #1;
    rst = 1'b0;
    enable = 1'b0;
    waitDrain("drain_reset");

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/ppg_phase_sequencer.md
Name: ppg_phase_sequencer

Overview:
Operation-phase sequencer for the PPG analog front end, run after the setting search has fixed per-LED DC compensation and PGA gain. Time-multiplexes the RED and IR LEDs and drives the matching DC_Comp/PGA_Gain for each phase. Waits out analog settling, then averages 4 ADC samples per phase. Hands each averaged sample to the downstream SpO2 datapath over a one-entry valid/ready register.

Parameters:
PHASE_LEN, 10, clock cycles per LED phase; PHASE_LEN >= SETTLE+5 is required.
SETTLE, 4, cycles ignored at phase start before accumulating.
ADC_W, 8, ADC sample width.

Ports:
CLK  in  1  system clock, single clock domain.
rst  in  1  asynchronous, active-high reset.
enable  in  1  run sequencing; low means return to IDLE.
cfg_load  in  1  one-cycle pulse; capture the four cfg_* inputs.
cfg_red_dc  in  7  RED DC compensation code.
cfg_red_pga  in  4  RED PGA gain.
cfg_ir_dc  in  7  IR DC compensation code.
cfg_ir_pga  in  4  IR PGA gain.
ADC  in  ADC_W  ADC sample, valid every cycle.
LED_RED  out  1  RED LED enable.
LED_IR  out  1  IR LED enable.
DC_Comp  out  7  DC compensation to the AFE.
PGA_Gain  out  4  PGA gain to the AFE.
sample_data  out  ADC_W  averaged sample.
sample_ch  out  2  channel tag: 0=RED, 1=IR, 2=AMB.
sample_valid  out  1  output register holds a sample.
sample_ready  in  1  consumer accepts the sample.
overrun  out  1  sticky flag: a sample was dropped.
overrun_clr  in  1  clears overrun.
busy  out  1  high when not in IDLE.

Behaviour:
- Reset values: LEDs 0, DC_Comp 64, PGA_Gain 0, sample_data 0, sample_ch 0, sample_valid 0, overrun 0, busy 0, state IDLE. Shadow config resets to DC 64 and PGA 0 for both channels; pend_cfg resets to 0.
- States: IDLE, RED, IR, and AMB (AMB only with the optional feature). Order is RED->IR->RED, or RED->IR->AMB->RED with the feature.
- IDLE->RED on the first clock with enable=1.
- Any state->IDLE on the clock after enable=0. LEDs go off and the accumulator is discarded. A sample already held in the output register is kept until it is taken.
- Phase counter cnt runs 0..PHASE_LEN-1 and wraps to 0 on the phase change.
- On entry to a phase (cnt=0), the outputs are registered to the new phase: LED, DC_Comp and PGA_Gain come from that channel's shadow config.
- In AMB, both LEDs are off and the IR settings are driven.
- Break-before-make: both LEDs are 0 during cnt=PHASE_LEN-1, so LED_RED and LED_IR are never high together.
- Accumulate: a 10-bit sum of ADC over cnt=SETTLE..SETTLE+3.
- Averaging: result = sum>>2, truncated. sample_valid rises on the clock after the 4th accumulated cycle, with sample_ch set to the current phase.
- Output register: a transfer happens on a cycle where sample_valid&&sample_ready are both high.
- New result and held sample on the same cycle:
  - if the held sample transfers that cycle, the new result is loaded with no overrun;
  - otherwise the new result is dropped and overrun is set.
- overrun_clr clears overrun; if a drop happens on the same cycle, the set wins.
- cfg_load sets pend_cfg. The shadow registers update from cfg_* at the next RED phase entry, or immediately if in IDLE. pend_cfg then clears.
- Config never changes mid-phase. A second cfg_load before it is applied overwrites the pending values; cfg_* are sampled at apply time, so they must be held stable.
- rst mid-phase forces all reset values asynchronously.

Optional Feature:
PPG_AMBIENT_PHASE_EN: when defined, the AMB phase is inserted after IR, with LEDs off, the IR DC/PGA settings, and a sample tagged ch=2. Downstream can then subtract ambient light. When undefined, there is no AMB state, sample_ch is never 2, and a cycle is 2*PHASE_LEN long.

Decomposition:
- Shared package ppg_pkg holds:
  - the state encodings ST_IDLE/ST_RED/ST_IR/ST_AMB;
  - the channel codes CH_RED=0, CH_IR=1, CH_AMB=2;
  - DC_COMP_RESET=64, DC_W=7, PGA_W=4.
- One natural sub-module, ppg_sample_avg: the settle window and 4-sample accumulator. Its interface is start, ADC, done and avg.

Test Plan:
1. Reset, enable=1, ADC constant 100, red_dc=50/pga=3, ir_dc=70/pga=5 loaded in IDLE -> the first LED_RED=1 shows DC_Comp=50 and PGA_Gain=3. The sample has ch=0, data=100, and valid rises 9 clocks after RED entry with default parameters (SETTLE=4).
2. ADC sequence 10,11,12,13 in the RED window -> data=11 (46>>2). The next phase is IR with LED_RED=0, and both LEDs were 0 at cnt=9.
3. Hold sample_ready=0 for 2 phases -> the first sample is kept, overrun=1. Then ready=1 with overrun_clr=1 -> transfer occurs and overrun=0.
4. cfg_load with red_dc=40 mid-IR phase -> DC_Comp stays 70 until the next RED entry, then becomes 40.
5. enable=0 at RED cnt=5 -> next clock IDLE, LEDs 0, no sample emitted; rst=1 mid-IR -> DC_Comp=64 immediately.
6. With PPG_AMBIENT_PHASE_EN -> the channel tag sequence is 0,1,2,0 and LEDs are off throughout AMB; without the macro the sequence is 0,1,0.
